// File: rtl/shifter_rr_controller_pkg.sv
// shifter_rr_controller_pkg: shared state encodings, direction constants and widths for the shift controller
package shifter_rr_controller_pkg;
  localparam int DATA_W = 16;
  localparam int AMT_W = 4;
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT = 1'b1;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } state_t;
  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction
endpackage

// File: rtl/shifter_rr_controller_shifter.sv
// shifter_rr_controller_shifter: 16-bit logarithmic barrel shifter, logical left/right
module shifter_rr_controller_shifter
  import shifter_rr_controller_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [AMT_W-1:0]  amt,
  input  logic              dir,
  output logic [DATA_W-1:0] y
);
  logic [DATA_W-1:0] stage [AMT_W+1];
  // left shifts reuse the right-shift stages on a bit-reversed word
  assign stage[0] = dir == DIR_LEFT ? bit_rev(data) : data;
  for (genvar s = 0; s < AMT_W; s++) begin : g_stage
    assign stage[s+1] = amt[s] ? stage[s] >> (1 << s) : stage[s];
  end
  assign y = dir == DIR_LEFT ? bit_rev(stage[AMT_W]) : stage[AMT_W];
endmodule

// File: rtl/shifter_rr_controller.sv
// shifter_rr_controller: round-robin sharing of one barrel shifter between two requesters; SHIFT_ROTATE_EN adds two-pass rotate
module shifter_rr_controller
  import shifter_rr_controller_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  input  logic [AMT_W-1:0]  amt0,
  input  logic              dir0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  input  logic [AMT_W-1:0]  amt1,
  input  logic              dir1,
`ifdef SHIFT_ROTATE_EN
  input  logic              rot0,
  input  logic              rot1,
`endif
  output logic              busy,
  output logic              grant,
  output logic [DATA_W-1:0] result,
  output logic              done0,
  output logic              done1
);
  state_t state, state_nx;
  logic rr, pick, any_req, rot, dir, sh_dir;
  logic [DATA_W-1:0] op, sh_out;
  logic [AMT_W-1:0] amt, sh_amt;
`ifdef SHIFT_ROTATE_EN
  logic rot_q;
  logic [DATA_W-1:0] partial;
  assign rot = rot_q;
  // second rotate pass shifts the other way by the complementary amount
  assign sh_amt = state == PASS2 ? AMT_W'(0) - amt : amt;
  assign sh_dir = state == PASS2 ? ~dir : dir;
`else
  assign rot = 1'b0;
  assign sh_amt = amt;
  assign sh_dir = dir;
`endif
  assign any_req = req0 | req1;
  assign pick = (req0 & req1) ? rr : req1;
  assign busy = state != IDLE;
  assign done0 = state == DONE && !grant;
  assign done1 = state == DONE && grant;
  shifter_rr_controller_shifter u_shifter (
    .data(op),
    .amt (sh_amt),
    .dir (sh_dir),
    .y   (sh_out)
  );
  always_comb begin
    state_nx = state == IDLE  ? (any_req ? PASS1 : IDLE) :
               state == PASS1 ? (rot ? PASS2 : DONE) :
               state == PASS2 ? DONE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      result <= '0;
      grant <= 1'b0;
      rr <= 1'b0;
      op <= '0;
      amt <= '0;
      dir <= DIR_RIGHT;
`ifdef SHIFT_ROTATE_EN
      rot_q <= 1'b0;
      partial <= '0;
`endif
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        grant <= pick;
        rr <= ~pick;
        op <= pick ? data1 : data0;
        amt <= pick ? amt1 : amt0;
        dir <= pick ? dir1 : dir0;
`ifdef SHIFT_ROTATE_EN
        rot_q <= pick ? rot1 : rot0;
`endif
      end
      if (state == PASS1 && !rot) result <= sh_out;
`ifdef SHIFT_ROTATE_EN
      if (state == PASS1 && rot) partial <= sh_out;
      if (state == PASS2) result <= partial | (amt == '0 ? '0 : sh_out);
`endif
    end
  end
endmodule
